uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
Parameters:
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum WAIT-state cycles allowed for tx_done after tx_start.
REQ-002 The block SHALL have parameter CNT_W, default 5, the width of the watchdog counter; TIMEOUT SHALL fit in CNT_W bits.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have ports:
- clk  in  1  baud-rate clock shared with the transmitter; one clock, reset is asynchronous and active-low
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  requester 0 byte accepted this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  8  requester 1 byte
- req1_ready  out  1  requester 1 byte accepted this cycle
- tx_enable  out  1  transmitter enable
- tx_start  out  1  transmitter start pulse
- tx_data  out  8  byte to the transmitter
- tx_done  in  1  transmitter end-of-frame pulse
- tx_busy  in  1  transmitter busy
- grant_id  out  1  requester owning the current transfer
- busy  out  1  arbiter not idle
- timeout  out  1  one-cycle watchdog-expiry pulse

Function
REQ-004 The FSM SHALL have states IDLE, SEND and WAIT and no others.
REQ-005 IDLE behaviour:
- When tx_busy=0 and at least one valid is high, the arbiter SHALL select one requester.
- It SHALL drive that requester's ready combinationally high.
- On that edge it SHALL latch the requester's data into tx_data, latch its index into grant_id, and go to SEND.
REQ-006 In IDLE with tx_busy=1, both readys SHALL be 0 and the arbiter SHALL remain in IDLE.
REQ-007 At most one ready SHALL be high in any cycle, and readys SHALL be high only in IDLE.
REQ-008 SEND SHALL last exactly one cycle with tx_start=1, then move to WAIT; tx_start SHALL be 0 in all other states.
- Latency: accept edge to tx_start high is 1 cycle.
REQ-009 tx_data and grant_id SHALL hold stable from the accept edge until return to IDLE.
REQ-010 WAIT behaviour:
- The watchdog counter SHALL clear on entering WAIT and increment each cycle.
- On tx_done=1 the arbiter SHALL return to IDLE.
- If the counter reaches TIMEOUT-1 without tx_done, it SHALL pulse timeout for one cycle and return to IDLE.
REQ-011 If tx_done and watchdog expiry occur in the same cycle, tx_done SHALL win: timeout stays 0.
REQ-012 A tx_done arriving in IDLE or SEND SHALL be ignored.
REQ-013 busy SHALL be 1 in SEND and WAIT, and 0 in IDLE.
REQ-014 tx_enable SHALL be 1 whenever rst_n=1.
REQ-015 The arbiter SHALL be able to accept a new byte on the first IDLE cycle after WAIT exits (no dead cycle beyond the tx_busy check).
REQ-016 A requester SHALL hold valid and data stable until it sees its ready.
- The arbiter SHALL NOT sample data when ready is low.

Reset
REQ-017 rst_n=0 SHALL asynchronously force the following, regardless of the state at assertion, aborting any transfer:
- state IDLE
- tx_start=0, tx_data=0, grant_id=0, busy=0, timeout=0, tx_enable=0
- watchdog counter 0
- last-grant register 1
REQ-018 After rst_n deasserts, the first acceptance SHALL occur no earlier than the first rising clk edge.

Configuration
REQ-019 With macro UART_TX_ARB_RR_EN defined, selection SHALL be round-robin:
- When both requesters are valid, the requester not equal to the last-grant register wins.
- The last-grant register SHALL update on every acceptance.
- With one requester valid, that requester wins.
REQ-020 Without UART_TX_ARB_RR_EN, selection SHALL be fixed priority: requester 0 wins whenever req0_valid=1, and no last-grant register SHALL exist.

Verification
REQ-021 The bench SHALL cover these scenarios:
- Single byte: req0_valid=1, req0_data=8'h68 → req0_ready 1 cycle, tx_start 1 cycle later with tx_data=8'h68, grant_id=0, busy until tx_done, then IDLE.
- Contention, RR on: both valid continuously (req0_data=8'h65, req1_data=8'h6C) → grant order 0,1,0,1, never two consecutive grants to the same requester.
- Contention, RR off: same stimulus → all grants to requester 0 while req0_valid=1; req1 served only after req0_valid drops.
- Watchdog: tx_done held 0 after tx_start → timeout pulses exactly TIMEOUT cycles after entering WAIT, busy drops the next cycle; a tx_done on the expiry cycle suppresses timeout.
- Transmitter busy: tx_busy=1 in IDLE with req1_valid=1 → no ready; accepted on the first cycle after tx_busy=0.
- Reset mid-transfer: rst_n pulsed low during WAIT → tx_start, busy, grant_id and timeout go 0 immediately; the next request is granted to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Arbitrates two byte requesters onto a single UART transmitter. A byte is
// accepted in IDLE (ready high for one requester), launched with a one-cycle
// tx_start in SEND, then WAIT holds until tx_done or the watchdog expires.
//
// Parameters:
//   TIMEOUT  maximum WAIT cycles allowed for tx_done after tx_start
//   CNT_W    watchdog counter width (TIMEOUT must fit in CNT_W bits)
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid/data/ready      requester 0 handshake (ready is combinational)
//   req1_valid/data/ready      requester 1 handshake (ready is combinational)
//   tx_enable, tx_start        transmitter enable and start pulse
//   tx_data                    byte to the transmitter, held until IDLE
//   tx_done, tx_busy           transmitter end-of-frame pulse and busy flag
//   grant_id                   requester owning the current transfer
//   busy                       arbiter not idle
//   timeout                    one-cycle watchdog-expiry pulse
//
// Configuration:
//   UART_TX_ARB_RR_EN  defined: round-robin selection with a last-grant
//                      register; undefined: fixed priority, requester 0 wins.

module uart_tx_arbiter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx_enable,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       tx_busy,
  output logic       grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_tx_data;
  logic             r_grant_id;
  logic             w_sel;
  logic             w_accept;
  logic             w_expire;

  assign w_accept = (r_state == IDLE) && !tx_busy && (req0_valid || req1_valid);

`ifdef UART_TX_ARB_RR_EN
  logic r_last_grant;

  // Under contention the requester that did not win last time is chosen.
  always_comb begin
    w_sel = ~req0_valid;
    if (req0_valid && req1_valid) w_sel = ~r_last_grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_sel;
  end
`else
  assign w_sel = ~req0_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // tx_done takes precedence over the watchdog when both land together.
  always_comb begin
    w_next   = r_state;
    w_expire = 1'b0;
    case (r_state)
      IDLE: if (w_accept) w_next = SEND;
      SEND: w_next = WAIT;
      WAIT: begin
        if (tx_done) begin
          w_next = IDLE;
        end else if (r_cnt == LP_LAST) begin
          w_next   = IDLE;
          w_expire = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter is cleared while in SEND so it reads zero on the first WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (r_state == SEND)   r_cnt <= '0;
    else if (r_state == WAIT)   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= '0;
      r_grant_id <= 1'b0;
    end else if (w_accept) begin
      r_tx_data  <= w_sel ? req1_data : req0_data;
      r_grant_id <= w_sel;
    end
  end

  assign req0_ready = w_accept && !w_sel;
  assign req1_ready = w_accept &&  w_sel;
  assign tx_enable  = rst_n;
  assign tx_start   = (r_state == SEND);
  assign tx_data    = r_tx_data;
  assign grant_id   = r_grant_id;
  assign busy       = (r_state != IDLE);
  assign timeout    = w_expire;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int TO = 6;
`ifdef UART_TX_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       tx_enable, tx_start, tx_done, tx_busy;
  logic [7:0] tx_data;
  logic       grant_id, busy, timeout;

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_item;
  logic       model_last;

  uart_tx_arbiter #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_enable  (tx_enable),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive point: just after a rising edge.
  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    tx_done    = 1'b0;
    tx_busy    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    drive_point();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0;
    tx_done = 1'b0; tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({tx_start, tx_data, grant_id, busy, timeout, tx_enable} !== 13'h0)
      $display("FAIL reset_outputs got=%h exp=%h",
               {tx_start, tx_data, grant_id, busy, timeout, tx_enable}, 13'h0);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_total++;
    if (tx_enable !== 1'b1) $display("FAIL reset_tx_enable got=%b exp=1", tx_enable);
    else n_pass++;
    model_last = 1'b1;
    drive_point();
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_data = 8'h68;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
    else n_pass++;
    exp_q.push_back({1'b0, 8'h68});
    model_last = 1'b0;
    drive_point();
    req0_valid = 1'b0; req0_data = '0;
    @(negedge clk);
    n_total++;
    if (tx_start !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL single_start got=%b exp=1", tx_start);
    end else begin
      exp_item = exp_q.pop_front();
      if ({grant_id, tx_data} !== exp_item)
        $display("FAIL single_sb got=%h exp=%h", {grant_id, tx_data}, exp_item);
      else n_pass++;
    end
    drive_point();
    @(negedge clk);
    n_total++;
    if ({tx_start, busy, grant_id, tx_data} !== {1'b0, 1'b1, 1'b0, 8'h68})
      $display("FAIL single_wait got=%h exp=%h", {tx_start, busy, grant_id, tx_data},
               {1'b0, 1'b1, 1'b0, 8'h68});
    else n_pass++;
    drive_point();
    tx_done = 1'b1;
    drive_point();
    tx_done = 1'b0;
    @(negedge clk);
    n_total++;
    if ({busy, tx_start, timeout} !== 3'b000)
      $display("FAIL single_idle got=%b exp=000", {busy, tx_start, timeout});
    else n_pass++;
    drive_point();
  endtask

  task automatic test_contention();
    logic exp_win;
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h65;
    req1_valid = 1'b1; req1_data = 8'h6C;
    for (int g = 0; g < 5; g++) begin
      if (g == 4) req0_valid = 1'b0;
      @(negedge clk);
      if (req0_valid && req1_valid) exp_win = RR ? ~model_last : 1'b0;
      else                          exp_win = ~req0_valid;
      n_total++;
      if ({req0_ready, req1_ready} !== {~exp_win, exp_win})
        $display("FAIL contention_ready[%0d] got=%b exp=%b", g,
                 {req0_ready, req1_ready}, {~exp_win, exp_win});
      else n_pass++;
      exp_q.push_back({exp_win, exp_win ? req1_data : req0_data});
      model_last = exp_win;
      drive_point();
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL contention_start[%0d] got=%b exp=1", g, tx_start);
      end else begin
        exp_item = exp_q.pop_front();
        if ({grant_id, tx_data} !== exp_item)
          $display("FAIL contention_sb[%0d] got=%h exp=%h", g, {grant_id, tx_data}, exp_item);
        else n_pass++;
      end
      drive_point();
      tx_done = 1'b1;
      drive_point();
      tx_done = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_watchdog();
    for (int pass = 0; pass < 2; pass++) begin
      req0_valid = 1'b1; req0_data = 8'hA5;
      @(negedge clk);
      n_total++;
      if (req0_ready !== 1'b1) $display("FAIL wd_ready[%0d] got=%b exp=1", pass, req0_ready);
      else n_pass++;
      exp_q.push_back({1'b0, 8'hA5});
      model_last = 1'b0;
      drive_point();
      req0_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (tx_start !== 1'b1 || exp_q.size() == 0) begin
        $display("FAIL wd_start[%0d] got=%b exp=1", pass, tx_start);
      end else begin
        exp_item = exp_q.pop_front();
        if ({grant_id, tx_data} !== exp_item)
          $display("FAIL wd_sb[%0d] got=%h exp=%h", pass, {grant_id, tx_data}, exp_item);
        else n_pass++;
      end
      for (int k = 0; k < TO; k++) begin
        drive_point();
        if (pass == 1 && k == TO - 1) tx_done = 1'b1;
        @(negedge clk);
        n_total++;
        if ({busy, timeout} !== {1'b1, (pass == 0 && k == TO - 1)})
          $display("FAIL wd_cycle[%0d.%0d] got=%b exp=%b", pass, k, {busy, timeout},
                   {1'b1, (pass == 0 && k == TO - 1)});
        else n_pass++;
      end
      drive_point();
      tx_done = 1'b0;
      @(negedge clk);
      n_total++;
      if ({busy, timeout} !== 2'b00)
        $display("FAIL wd_exit[%0d] got=%b exp=00", pass, {busy, timeout});
      else n_pass++;
      drive_point();
    end
  endtask

  task automatic test_tx_busy();
    tx_busy = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h6C;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_total++;
      if ({req0_ready, req1_ready, busy} !== 3'b000)
        $display("FAIL txbusy_hold[%0d] got=%b exp=000", c, {req0_ready, req1_ready, busy});
      else n_pass++;
      drive_point();
    end
    tx_busy = 1'b0;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b01)
      $display("FAIL txbusy_accept got=%b exp=01", {req0_ready, req1_ready});
    else n_pass++;
    exp_q.push_back({1'b1, 8'h6C});
    model_last = 1'b1;
    drive_point();
    req1_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (tx_start !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL txbusy_start got=%b exp=1", tx_start);
    end else begin
      exp_item = exp_q.pop_front();
      if ({grant_id, tx_data} !== exp_item)
        $display("FAIL txbusy_sb got=%h exp=%h", {grant_id, tx_data}, exp_item);
      else n_pass++;
    end
    drive_point();
    tx_done = 1'b1;
    drive_point();
    tx_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    req1_valid = 1'b1; req1_data = 8'h3C;
    @(negedge clk);
    exp_q.push_back({1'b1, 8'h3C});
    drive_point();
    req1_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (tx_start !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL rstmid_start got=%b exp=1", tx_start);
    end else begin
      exp_item = exp_q.pop_front();
      if ({grant_id, tx_data} !== exp_item)
        $display("FAIL rstmid_sb got=%h exp=%h", {grant_id, tx_data}, exp_item);
      else n_pass++;
    end
    drive_point();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({tx_start, busy, grant_id, timeout, tx_data, tx_enable} !== 13'h0)
      $display("FAIL rstmid_async got=%h exp=%h",
               {tx_start, busy, grant_id, timeout, tx_data, tx_enable}, 13'h0);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
    drive_point();
    req0_valid = 1'b1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_data = 8'h22;
    @(negedge clk);
    n_total++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL rstmid_regrant got=%b exp=10", {req0_ready, req1_ready});
    else n_pass++;
    exp_q.push_back({1'b0, 8'h11});
    model_last = 1'b0;
    drive_point();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (tx_start !== 1'b1 || exp_q.size() == 0) begin
      $display("FAIL rstmid_start2 got=%b exp=1", tx_start);
    end else begin
      exp_item = exp_q.pop_front();
      if ({grant_id, tx_data} !== exp_item)
        $display("FAIL rstmid_sb2 got=%h exp=%h", {grant_id, tx_data}, exp_item);
      else n_pass++;
    end
    drive_point();
    tx_done = 1'b1;
    drive_point();
    tx_done = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL rstmid_idle got=%b exp=0", busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_watchdog();
    test_tx_busy();
    test_reset_mid();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
